// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the chunked serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Number of chunk-sized steps needed to cover a full operand.
    function automatic int nchunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Legal geometry: non-empty operands that split evenly into chunks.
    function automatic bit config_ok(input int width, input int chunk);
        return (width >= 1) && (chunk >= 1) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from 1-bit full-adder cells.
// Besides the sum and carry-out it exposes the carry into its top bit so the
// caller can derive signed overflow without re-examining the operands.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module chunk_adder
    import serial_adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);
    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    assign cout = carry[CHUNK];
    assign cmsb = carry[CHUNK-1];
endmodule

// File: rtl/serial_adder.sv
// Chunked serial adder: adds CHUNK bits per clock with a registered carry,
// finishing a WIDTH-bit add in WIDTH/CHUNK cycles. Valid/ready on both sides,
// reports unsigned carry-out and signed overflow.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN, which adds
// a 'sub' input sampled at acceptance (B inverted, carry-in forced to 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NCH = nchunks(WIDTH, CHUNK);
    // One extra bit so the counter can reach NCH without wrapping.
    localparam int CW  = $clog2(NCH) + 1;

    if (!config_ok(WIDTH, CHUNK)) begin : g_cfg_err
        $error("serial_adder: WIDTH must be >= 1 and an integer multiple of CHUNK");
    end

    state_t                 state;
    state_t                 state_nxt;
    logic [WIDTH-1:0]       a_sr;
    logic [WIDTH-1:0]       b_sr;
    logic [WIDTH-1:0]       sum_r;
    logic                   carry_r;
    logic [CW-1:0]          cnt;
    logic                   cout_r;
    logic                   ovf_r;
    logic [WIDTH-1:0]       b_load;
    logic                   c_load;
    logic [CHUNK-1:0]       ch_sum;
    logic                   ch_cout;
    logic                   ch_cmsb;
    logic                   last;
    logic [WIDTH+CHUNK-1:0] sum_cat;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_sr[CHUNK-1:0]),
        .b    (b_sr[CHUNK-1:0]),
        .cin  (carry_r),
        .sum  (ch_sum),
        .cout (ch_cout),
        .cmsb (ch_cmsb)
    );

    assign last    = (cnt == CW'(NCH - 1));
    // New chunk enters at the MSB end; the upper WIDTH bits are the shifted sum.
    assign sum_cat = {ch_sum, sum_r};

    // Select the B operand and initial carry to capture at acceptance.
    always_comb begin
        b_load = b;
        c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_load = ~b;
            c_load = 1'b1;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shift registers, running carry, partial sum and final flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sr    <= a;
            b_sr    <= b_load;
            sum_r   <= '0;
            carry_r <= c_load;
            cnt     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (state == RUN) begin
            a_sr    <= a_sr >> CHUNK;
            b_sr    <= b_sr >> CHUNK;
            sum_r   <= sum_cat[WIDTH+CHUNK-1:CHUNK];
            carry_r <= ch_cout;
            cnt     <= cnt + CW'(1);
            if (last) begin
                cout_r <= ch_cout;
                ovf_r  <= ch_cmsb ^ ch_cout;
            end
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
endmodule
